// File: rtl/lsu_ctrl.sv
// Load/store unit, MEM stage: data-memory port initiator with alignment,
// funct3 legality, lane steering, load extension and transaction timeout.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_load,
    input  logic              ex_store,
    input  logic [2:0]        ex_funct3,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [31:0]       ex_wdata,
    input  logic [4:0]        ex_rd,
    output logic              lsu_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              st_done,
    output logic              exc_valid,
    output logic [1:0]        exc_cause
);

    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              load_q;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;
    logic [4:0]        rd_q;

    logic              lsu_ready_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_be_q;
    logic [31:0]       mem_wdata_q;
    logic              wb_valid_q;
    logic [4:0]        wb_rd_q;
    logic [31:0]       wb_data_q;
    logic              st_done_q;
    logic              exc_valid_q;
    logic [1:0]        exc_cause_q;

    logic              illegal_c;
    logic              misaligned_c;
    logic [3:0]        be_c;
    logic [31:0]       wdata_c;
    logic [7:0]        byte_c;
    logic [15:0]       half_c;
    logic [31:0]       ext_c;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic              cnt_expired_c;

    // Decode the offered op: legality, alignment, byte enables and lane-steered store data.
    always_comb begin
        illegal_c    = 1'b0;
        misaligned_c = 1'b0;
        be_c         = 4'b1111;
        wdata_c      = ex_wdata;

        case (ex_funct3)
            3'b011, 3'b110, 3'b111: illegal_c = 1'b1;
            3'b100, 3'b101:         illegal_c = ex_store;
            default:                illegal_c = 1'b0;
        endcase
        if (ex_load && ex_store) begin
            illegal_c = 1'b1;
        end

        case (ex_funct3)
            3'b001, 3'b101: misaligned_c = ex_addr[0];
            3'b010:         misaligned_c = |ex_addr[1:0];
            default:        misaligned_c = 1'b0;
        endcase

        case (ex_funct3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << ex_addr[1:0];
                wdata_c = 32'(ex_wdata[7:0]) << {ex_addr[1:0], 3'b000};
            end
            2'b01: begin
                be_c    = 4'b0011 << ex_addr[1:0];
                wdata_c = ex_addr[1] ? {ex_wdata[15:0], 16'h0000} : {16'h0000, ex_wdata[15:0]};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = ex_wdata;
            end
        endcase
    end

    // Select the addressed byte/half of the read word and extend per the captured funct3.
    always_comb begin
        byte_c = mem_rdata[{off_q, 3'b000} +: 8];
        half_c = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ext_c = {{24{byte_c[7]}}, byte_c};
            3'b001:  ext_c = {{16{half_c[15]}}, half_c};
            3'b100:  ext_c = {24'h000000, byte_c};
            3'b101:  ext_c = {16'h0000, half_c};
            default: ext_c = mem_rdata;
        endcase
    end

    // Timeout counter increment and expiry detect for REQ/WAIT.
    always_comb begin
        cnt_inc_c     = cnt_q + CNT_W'(1);
        cnt_expired_c = (cnt_inc_c == CNT_W'(TIMEOUT));
    end

    // Transaction FSM with all outputs registered; pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            load_q      <= 1'b0;
            funct3_q    <= '0;
            off_q       <= '0;
            rd_q        <= '0;
            lsu_ready_q <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            st_done_q   <= 1'b0;
            exc_valid_q <= 1'b0;
            exc_cause_q <= '0;
        end else begin
            wb_valid_q  <= 1'b0;
            st_done_q   <= 1'b0;
            exc_valid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (ex_valid && (ex_load || ex_store)) begin
                        if (illegal_c) begin
                            exc_valid_q <= 1'b1;
                            exc_cause_q <= CAUSE_ILLEGAL;
                        end else if (misaligned_c) begin
                            exc_valid_q <= 1'b1;
                            exc_cause_q <= CAUSE_MISALIGN;
                        end else begin
                            state_q     <= S_REQ;
                            cnt_q       <= '0;
                            load_q      <= ex_load;
                            funct3_q    <= ex_funct3;
                            off_q       <= ex_addr[1:0];
                            rd_q        <= ex_rd;
                            lsu_ready_q <= 1'b0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= ex_store;
                            mem_addr_q  <= {ex_addr[ADDR_W-1:2], 2'b00};
                            mem_be_q    <= be_c;
                            mem_wdata_q <= ex_store ? wdata_c : 32'h0000_0000;
                        end
                    end
                end

                S_REQ: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        cnt_q     <= '0;
                        if (load_q) begin
                            state_q <= S_WAIT;
                        end else begin
                            state_q     <= S_IDLE;
                            st_done_q   <= 1'b1;
                            lsu_ready_q <= 1'b1;
                        end
                    end else if (cnt_expired_c) begin
                        state_q     <= S_IDLE;
                        mem_req_q   <= 1'b0;
                        lsu_ready_q <= 1'b1;
                        exc_valid_q <= 1'b1;
                        exc_cause_q <= CAUSE_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_inc_c;
                    end
                end

                S_WAIT: begin
                    if (mem_rvalid) begin
                        state_q     <= S_IDLE;
                        lsu_ready_q <= 1'b1;
                        wb_valid_q  <= 1'b1;
                        wb_rd_q     <= rd_q;
                        wb_data_q   <= ext_c;
                    end else if (cnt_expired_c) begin
                        state_q     <= S_IDLE;
                        lsu_ready_q <= 1'b1;
                        exc_valid_q <= 1'b1;
                        exc_cause_q <= CAUSE_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_inc_c;
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    lsu_ready_q <= 1'b1;
                    mem_req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign lsu_ready = lsu_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign st_done   = st_done_q;
    assign exc_valid = exc_valid_q;
    assign exc_cause = exc_cause_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed cases plus randomized ops against a rule-level model.
module tb_lsu_ctrl;

    localparam int unsigned TMO = 16;
    localparam int unsigned AW  = 32;

    logic          clk;
    logic          rst;
    logic          ex_valid;
    logic          ex_load;
    logic          ex_store;
    logic [2:0]    ex_funct3;
    logic [AW-1:0] ex_addr;
    logic [31:0]   ex_wdata;
    logic [4:0]    ex_rd;
    logic          lsu_ready;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [31:0]   mem_rdata;
    logic          wb_valid;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_data;
    logic          st_done;
    logic          exc_valid;
    logic [1:0]    exc_cause;

    int n_cmp = 0;
    int n_err = 0;

    lsu_ctrl #(.TIMEOUT(TMO), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_load    (ex_load),
        .ex_store   (ex_store),
        .ex_funct3  (ex_funct3),
        .ex_addr    (ex_addr),
        .ex_wdata   (ex_wdata),
        .ex_rd      (ex_rd),
        .lsu_ready  (lsu_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .st_done    (st_done),
        .exc_valid  (exc_valid),
        .exc_cause  (exc_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (access-size rules in plain arithmetic) ----------------
    function automatic int m_nbytes(input logic [2:0] f3);
        int sz;
        sz = int'(f3) % 4;
        if (sz == 0) return 1;
        if (sz == 1) return 2;
        return 4;
    endfunction

    function automatic logic [1:0] m_cause(input logic ld, input logic st,
                                           input logic [2:0] f3, input logic [31:0] a);
        if (ld && st) return 2'd2;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 2'd2;
        if (st && f3 >= 3'd4) return 2'd2;
        if ((a % 32'(m_nbytes(f3))) != 32'd0) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int off;
        int v;
        off = int'(a % 32'd4);
        v = ((1 << m_nbytes(f3)) - 1) << off;
        return 4'(v);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] wd);
        logic [63:0] m;
        logic [63:0] v;
        int off;
        off = int'(a % 32'd4);
        m = (64'd1 << (8 * m_nbytes(f3))) - 64'd1;
        v = ({32'd0, wd} & m) << (8 * off);
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rdata);
        logic [63:0] m;
        logic [63:0] v;
        int off;
        int nb;
        nb  = m_nbytes(f3);
        off = int'(a % 32'd4);
        m = (64'd1 << (8 * nb)) - 64'd1;
        v = ({32'd0, rdata} >> (8 * off)) & m;
        if (!f3[2] && nb < 4 && v[8 * nb - 1]) v = v | ~m;
        return v[31:0];
    endfunction

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic junk_ex(input bit allow_valid);
        ex_valid  = allow_valid ? 1'($urandom_range(0, 1)) : 1'b0;
        ex_load   = 1'($urandom_range(0, 1));
        ex_store  = 1'($urandom_range(0, 1));
        ex_funct3 = 3'($urandom);
        ex_addr   = $urandom;
        ex_wdata  = $urandom;
        ex_rd     = 5'($urandom);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"},     32'(lsu_ready), 32'd1);
        chk({tag, "_req"},       32'(mem_req),   32'd0);
        chk({tag, "_we"},        32'(mem_we),    32'd0);
        chk({tag, "_addr"},      mem_addr,       32'd0);
        chk({tag, "_be"},        32'(mem_be),    32'd0);
        chk({tag, "_wdata"},     mem_wdata,      32'd0);
        chk({tag, "_wb_valid"},  32'(wb_valid),  32'd0);
        chk({tag, "_wb_rd"},     32'(wb_rd),     32'd0);
        chk({tag, "_wb_data"},   wb_data,        32'd0);
        chk({tag, "_st_done"},   32'(st_done),   32'd0);
        chk({tag, "_exc_valid"}, 32'(exc_valid), 32'd0);
        chk({tag, "_exc_cause"}, 32'(exc_cause), 32'd0);
    endtask

    // Offer one op in IDLE and follow it to completion, checking every cycle.
    // gnt_dly / rv_dly >= TMO means the memory never answers in time.
    task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                          input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
        logic [1:0]  cause;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [31:0] e_addr;
        logic [31:0] e_ld;
        bit          done;
        cause  = m_cause(ld, st, f3, addr);
        e_be   = m_be(f3, addr);
        e_wd   = m_wdata(f3, addr, wd);
        e_addr = addr & 32'hFFFF_FFFC;
        e_ld   = m_load(f3, addr, rdata);

        chk("ready_before_op", 32'(lsu_ready), 32'd1);
        ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3;
        ex_addr = addr; ex_wdata = wd; ex_rd = rd;
        step();
        junk_ex(1'b0);

        if (cause != 2'd0) begin
            chk("exc_valid",      32'(exc_valid), 32'd1);
            chk("exc_cause",      32'(exc_cause), 32'(cause));
            chk("exc_no_req",     32'(mem_req),   32'd0);
            chk("exc_ready",      32'(lsu_ready), 32'd1);
            chk("exc_no_others",  32'({wb_valid, st_done}), 32'd0);
            step();
            chk("exc_pulse_once", 32'(exc_valid), 32'd0);
            return;
        end

        // REQ phase: payload stable until grant or timeout
        done = 1'b0;
        for (int i = 0; i < int'(TMO); i++) begin
            chk("req_valid",  32'(mem_req),   32'd1);
            chk("req_we",     32'(mem_we),    32'(st));
            chk("req_addr",   mem_addr,       e_addr);
            chk("req_be",     32'(mem_be),    32'(e_be));
            if (st) chk("req_wdata", mem_wdata, e_wd);
            chk("req_ready",  32'(lsu_ready), 32'd0);
            chk("req_pulses", 32'({wb_valid, st_done, exc_valid}), 32'd0);
            junk_ex(1'b1);
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = $urandom;
            if (i == gnt_dly) begin
                mem_gnt = 1'b1;
                done = 1'b1;
            end
            step();
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            junk_ex(1'b0);
            if (done) break;
        end

        if (!done) begin
            chk("req_tmo_exc",    32'(exc_valid), 32'd1);
            chk("req_tmo_cause",  32'(exc_cause), 32'd3);
            chk("req_tmo_req",    32'(mem_req),   32'd0);
            chk("req_tmo_ready",  32'(lsu_ready), 32'd1);
            step();
            chk("req_tmo_once",   32'(exc_valid), 32'd0);
            return;
        end

        if (st) begin
            chk("st_done",        32'(st_done),   32'd1);
            chk("st_ready",       32'(lsu_ready), 32'd1);
            chk("st_req_drop",    32'(mem_req),   32'd0);
            chk("st_no_others",   32'({wb_valid, exc_valid}), 32'd0);
            step();
            chk("st_done_once",   32'(st_done),   32'd0);
            return;
        end

        // WAIT phase: response no earlier than one cycle after grant
        done = 1'b0;
        for (int i = 0; i < int'(TMO); i++) begin
            chk("wait_req",    32'(mem_req),   32'd0);
            chk("wait_ready",  32'(lsu_ready), 32'd0);
            chk("wait_pulses", 32'({wb_valid, st_done, exc_valid}), 32'd0);
            junk_ex(1'b1);
            if (i == rv_dly) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rdata;
                done = 1'b1;
            end
            step();
            mem_rvalid = 1'b0; mem_rdata = $urandom;
            junk_ex(1'b0);
            if (done) break;
        end

        if (!done) begin
            chk("wait_tmo_exc",   32'(exc_valid), 32'd1);
            chk("wait_tmo_cause", 32'(exc_cause), 32'd3);
            chk("wait_tmo_ready", 32'(lsu_ready), 32'd1);
            chk("wait_tmo_wb",    32'(wb_valid),  32'd0);
            mem_rvalid = 1'b1;
            step();
            mem_rvalid = 1'b0;
            chk("late_rvalid_wb", 32'(wb_valid),  32'd0);
            chk("wait_tmo_once",  32'(exc_valid), 32'd0);
            return;
        end

        chk("wb_valid",     32'(wb_valid),  32'd1);
        chk("wb_rd",        32'(wb_rd),     32'(rd));
        chk("wb_data",      wb_data,        e_ld);
        chk("wb_ready",     32'(lsu_ready), 32'd1);
        chk("wb_no_others", 32'({st_done, exc_valid}), 32'd0);
        step();
        chk("wb_once",      32'(wb_valid),  32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic ld;
        logic st;
        logic [2:0] f3;
        int sel;
        int gd;
        int rv;

        rst = 1'b1;
        junk_ex(1'b0);
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        step();
        step();
        chk_reset_vals("reset");
        rst = 1'b0;

        // LW 0x10: grant immediate, response next cycle
        run_op(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'd0, 5'd7, 0, 0, 32'hDEAD_BEEF);
        // LB / LBU 0x13, LHU 0x12
        run_op(1'b1, 1'b0, 3'b000, 32'h0000_0013, 32'd0, 5'd3, 0, 0, 32'h8000_0000);
        run_op(1'b1, 1'b0, 3'b100, 32'h0000_0013, 32'd0, 5'd4, 0, 0, 32'h8000_0000);
        run_op(1'b1, 1'b0, 3'b101, 32'h0000_0012, 32'd0, 5'd5, 1, 2, 32'hBEEF_0000);
        run_op(1'b1, 1'b0, 3'b001, 32'h0000_0016, 32'd0, 5'd6, 0, 1, 32'h8001_7FFF);
        // SB 0x21 with grant after 3 cycles
        run_op(1'b0, 1'b1, 3'b000, 32'h0000_0021, 32'h0000_00AB, 5'd0, 3, 0, 32'd0);
        run_op(1'b0, 1'b1, 3'b001, 32'h0000_0032, 32'h1234_CAFE, 5'd0, 0, 0, 32'd0);
        run_op(1'b0, 1'b1, 3'b010, 32'h0000_0040, 32'hA5A5_0F0F, 5'd0, 2, 0, 32'd0);
        // exceptions: misaligned, illegal, illegal-over-misaligned, load+store
        run_op(1'b1, 1'b0, 3'b010, 32'h0000_0002, 32'd0, 5'd1, 0, 0, 32'd0);
        run_op(1'b0, 1'b1, 3'b101, 32'h0000_0004, 32'd0, 5'd1, 0, 0, 32'd0);
        run_op(1'b0, 1'b1, 3'b111, 32'h0000_0001, 32'd0, 5'd1, 0, 0, 32'd0);
        run_op(1'b1, 1'b1, 3'b010, 32'h0000_0008, 32'd0, 5'd1, 0, 0, 32'd0);
        // ex_valid with neither load nor store is ignored
        ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = 3'b010; ex_addr = 32'h44;
        step();
        ex_valid = 1'b0;
        chk("noop_req",    32'(mem_req),   32'd0);
        chk("noop_ready",  32'(lsu_ready), 32'd1);
        chk("noop_pulses", 32'({wb_valid, st_done, exc_valid}), 32'd0);
        // WAIT timeout with late response, then REQ timeout
        run_op(1'b1, 1'b0, 3'b010, 32'h0000_0050, 32'd0, 5'd9, 0, 100, 32'h1111_2222);
        run_op(1'b0, 1'b1, 3'b010, 32'h0000_0054, 32'h7777_8888, 5'd0, 100, 0, 32'd0);

        // reset for one cycle during WAIT
        ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = 3'b010;
        ex_addr = 32'h0000_0060; ex_rd = 5'd12;
        step();
        ex_valid = 1'b0;
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("rst_wait_entry_req", 32'(mem_req), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_vals("rst_mid");
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step();
        mem_rvalid = 1'b0;
        chk("rst_mid_no_wb",  32'(wb_valid),  32'd0);
        chk("rst_mid_no_exc", 32'(exc_valid), 32'd0);
        chk("rst_mid_ready",  32'(lsu_ready), 32'd1);
        run_op(1'b1, 1'b0, 3'b010, 32'h0000_0060, 32'd0, 5'd12, 0, 0, 32'h0BAD_C0DE);

        // randomized ops
        for (int n = 0; n < 80; n++) begin
            sel = int'($urandom_range(0, 19));
            ld = (sel == 0) || (sel < 10);
            st = (sel == 0) || (sel >= 10);
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end else begin
                f3 = 3'($urandom);
            end
            gd = ($urandom_range(0, 15) == 0) ? 40 : int'($urandom_range(0, 4));
            rv = ($urandom_range(0, 15) == 0) ? 40 : int'($urandom_range(0, 4));
            run_op(ld, st, f3, $urandom, $urandom, 5'($urandom), gd, rv, $urandom);
            if ($urandom_range(0, 3) == 0) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit in the RISC-V core's MEM stage; initiator side of the data-memory port.
- Accepts one load/store per transaction from EX and checks alignment and funct3.
- Drives a word-addressed memory request with byte enables and lane-shifted store data, then waits for grant and read response.
- Extracts and sign/zero-extends load data; returns it to writeback with the destination register.
- Stalls the pipeline while a transaction is outstanding.

Parameters:
- TIMEOUT, 16: cycles allowed in REQ or WAIT before the transaction aborts with a bus error; legal range 2..255.
- ADDR_W, 32: byte address width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  operation offered this cycle
- ex_load  in  1  operation is a load
- ex_store  in  1  operation is a store; ex_load and ex_store both high is illegal
- ex_funct3  in  3  width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only)
- ex_addr  in  ADDR_W  byte address
- ex_wdata  in  32  store data, right-justified
- ex_rd  in  5  load destination register
- lsu_ready  out  1  high only in IDLE; an op is accepted when ex_valid && lsu_ready
- mem_req  out  1  request valid
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word-aligned address; bits [1:0] always 0
- mem_be  out  4  byte enables
- mem_wdata  out  32  store data shifted to the addressed lanes
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  full read word
- wb_valid  out  1  one-cycle pulse: load result valid
- wb_rd  out  5  destination register for wb_data
- wb_data  out  32  extended load result
- st_done  out  1  one-cycle pulse: store accepted by memory
- exc_valid  out  1  one-cycle pulse: exception
- exc_cause  out  2  01 misaligned, 10 illegal funct3, 11 bus timeout

Behaviour:
- Reset (synchronous): state IDLE; timeout counter 0; all captured registers 0. Outputs on the cycle after rst is sampled high: lsu_ready=1; mem_req=0, mem_we=0; mem_addr, mem_be, mem_wdata = 0; wb_valid=0, wb_rd=0, wb_data=0; st_done=0; exc_valid=0, exc_cause=0.
- Reset mid-transaction abandons it immediately: no wb_valid, st_done or exc_valid pulse; a later mem_gnt or mem_rvalid is ignored.
- States:
  - IDLE: accept an op. If it is illegal or misaligned, pulse exc_valid on the next cycle and stay in IDLE. Otherwise capture the op and go to REQ. ex_valid with neither ex_load nor ex_store is ignored.
  - REQ: hold mem_req=1 with all mem_* outputs stable until mem_gnt. On a store grant, go to IDLE with st_done pulsed on the next cycle. On a load grant, go to WAIT.
  - WAIT: mem_req=0. On mem_rvalid, register the extended result; wb_valid pulses on the next cycle and the state returns to IDLE.
- mem_rvalid is ignored outside WAIT, including in the grant cycle itself. The earliest response is one cycle after grant.
- Legality checks:
  - Illegal: funct3 011, 110 or 111; funct3 100 or 101 on a store; ex_load and ex_store both high.
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=00.
  - If both apply, report illegal (cause 10).
- Byte enables: B -> 0001 << addr[1:0]; H -> 0011 << addr[1:0]; W -> 1111. mem_be is driven for loads and stores.
- Store data: B data is replicated into the addressed lane; H data into the addressed half; W unchanged. Unaddressed lanes are don't-care but shall be 0.
- Load extract: select byte or half by addr[1:0]. B/H sign-extend; BU/HU zero-extend; W passes unchanged.
- Timeout: the counter clears on entry to REQ and on the REQ->WAIT transition, and increments every cycle in REQ or WAIT. When it reaches TIMEOUT: mem_req drops, exc_valid pulses with cause 11 on the next cycle, and the state returns to IDLE.
- Latency, op accepted at cycle N:
  - mem_req is high from N+1.
  - Store with gnt at N+1: st_done at N+2, lsu_ready at N+2.
  - Load with gnt at N+1 and rvalid at N+2: wb_valid at N+3.
- Pulse exclusivity: wb_valid, st_done and exc_valid are each high for exactly one cycle, and never together.
- lsu_ready=0 in REQ and WAIT. The pipeline holds EX while ex_valid && !lsu_ready.

Test Plan:
- Reset, then LW addr 0x0000_0010 with gnt immediate and rvalid next cycle returning 0xDEAD_BEEF -> mem_addr 0x10, mem_be 1111, wb_data 0xDEADBEEF, wb_valid exactly 3 cycles after accept.
- LB addr 0x13 with rdata 0x80_00_00_00 -> be 1000, wb_data 0xFFFF_FF80; repeat as LBU -> 0x0000_0080; LHU addr 0x12 with rdata 0xBEEF_0000 -> 0x0000_BEEF.
- SB addr 0x21, wdata 0x0000_00AB, gnt delayed 3 cycles -> mem_req and all mem_* outputs stable for 4 cycles, be 0010, mem_wdata[15:8]=0xAB, st_done pulses once.
- LW addr 0x02 -> exc_cause 01, no mem_req; SH funct3 101 -> exc_cause 10; SW addr 0x01 with funct3 111 -> cause 10.
- Load granted but no rvalid, TIMEOUT=16 -> exc_cause 11 after 16 WAIT cycles, lsu_ready returns; a late rvalid produces no wb_valid.
- rst asserted for one cycle during WAIT -> all outputs at reset values the next cycle, no pulses; a subsequent LW completes normally.
